// File: rtl/crc_akis_denetleyici_pkg.sv
// Shared types and constants for the CRC frame sequencer.
package crc_akis_paket;

  // Sequencer states: idle/accept beat, issue request, await result, present final CRC.
  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    CIKIS = 2'd3
  } durum_e;

  // Beat size codes, identical to the CRC unit's instruction bits {21,20}.
  localparam logic [1:0] BOYUT_B = 2'b00;
  localparam logic [1:0] BOYUT_H = 2'b01;
  localparam logic [1:0] BOYUT_W = 2'b10;

  localparam logic [31:0] CRC_BASLANGIC = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_SON_XOR   = 32'hFFFF_FFFF;

  // Keep only the bytes that belong to the beat; size 11 behaves as a word.
  function automatic logic [31:0] veri_maskele(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] m;
    case (size)
      BOYUT_B: m = {24'h0, data[7:0]};
      BOYUT_H: m = {16'h0, data[15:0]};
      default: m = data;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/crc_akis_denetleyici.sv
// Frame-level CRC-32 / CRC-32C sequencer driving the bit-manipulation CRC unit.
// Every channel uses valid/ready: a transfer happens on a rising clock edge where
// both valid and ready are high; a source keeps valid and its payload stable
// until that edge, and a sink may raise or drop ready freely.
module crc_akis_denetleyici
  import crc_akis_paket::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // input beat stream
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [XLEN-1:0] s_data_i,
  input  logic [1:0]      s_size_i,
  input  logic            s_last_i,
  input  logic            s_castagnoli_i,
  // request channel to the CRC unit
  output logic            crc_valid_o,
  input  logic            crc_ready_i,
  output logic [XLEN-1:0] crc_value_o,
  output logic            crc_bit20_o,
  output logic            crc_bit21_o,
  output logic            crc_bit23_o,
  // result channel from the CRC unit
  input  logic            crc_valid_i,
  output logic            crc_ready_o,
  input  logic [XLEN-1:0] crc_result_i,
  // final CRC
  output logic            sonuc_valid_o,
  input  logic            sonuc_ready_i,
  output logic [XLEN-1:0] sonuc_crc_o,
  // debug view of the sequencer state
  output logic [1:0]      durum_o
);

  durum_e          durum_q, durum_d;
  logic [XLEN-1:0] r_q, r_d;             // running (non-inverted) CRC
  logic [XLEN-1:0] islenen_q, islenen_d; // operand held for the request channel
  logic [1:0]      boyut_q, boyut_d;
  logic            ilk_q, ilk_d;         // next beat opens a new frame
  logic            c_q, c_d;             // Castagnoli select for the whole frame
  logic            son_q, son_d;         // current beat closes the frame
  logic            aktif_q, aktif_d;     // keeps s_ready_o low until the first edge after reset

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    durum_d       = durum_q;
    r_d           = r_q;
    islenen_d     = islenen_q;
    boyut_d       = boyut_q;
    ilk_d         = ilk_q;
    c_d           = c_q;
    son_d         = son_q;
    aktif_d       = 1'b1;
    s_ready_o     = 1'b0;
    crc_valid_o   = 1'b0;
    crc_ready_o   = 1'b0;
    sonuc_valid_o = 1'b0;
    case (durum_q)
      BOSTA: begin
        s_ready_o = aktif_q;
        if (s_valid_i && aktif_q) begin
          // Full-width XOR so the unit still sees the untouched upper CRC bits.
          islenen_d = r_q ^ veri_maskele(s_data_i, s_size_i);
          boyut_d   = (s_size_i == 2'b11) ? BOYUT_W : s_size_i;
          son_d     = s_last_i;
          if (ilk_q) c_d = s_castagnoli_i;
          ilk_d     = 1'b0;
          durum_d   = ISTEK;
        end
      end
      ISTEK: begin
        crc_valid_o = 1'b1;
        if (crc_ready_i) durum_d = BEKLE;
      end
      BEKLE: begin
        crc_ready_o = 1'b1;
        if (crc_valid_i) begin
          r_d     = crc_result_i;
          durum_d = son_q ? CIKIS : BOSTA;
        end
      end
      CIKIS: begin
        sonuc_valid_o = 1'b1;
        if (sonuc_ready_i) begin
          r_d     = CRC_BASLANGIC;
          ilk_d   = 1'b1;
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q   <= BOSTA;
      r_q       <= CRC_BASLANGIC;
      islenen_q <= '0;
      boyut_q   <= BOYUT_B;
      ilk_q     <= 1'b1;
      c_q       <= 1'b0;
      son_q     <= 1'b0;
      aktif_q   <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      r_q       <= r_d;
      islenen_q <= islenen_d;
      boyut_q   <= boyut_d;
      ilk_q     <= ilk_d;
      c_q       <= c_d;
      son_q     <= son_d;
      aktif_q   <= aktif_d;
    end
  end

  assign crc_value_o = islenen_q;
  assign crc_bit20_o = boyut_q[0];
  assign crc_bit21_o = boyut_q[1];
  assign crc_bit23_o = c_q;
  assign sonuc_crc_o = r_q ^ CRC_SON_XOR;
  assign durum_o     = durum_q;

endmodule

// File: tb/tb_crc_akis_denetleyici.sv
// Bench for crc_akis_denetleyici: a behavioural CRC unit answers requests,
// and each frame's final CRC is compared with a byte-stream CRC model.
module tb_crc_akis_denetleyici;

  logic        clk, rst_n;
  logic        s_valid_i, s_ready_o, s_last_i, s_castagnoli_i;
  logic [31:0] s_data_i;
  logic [1:0]  s_size_i;
  logic        crc_valid_o, crc_ready_i, crc_bit20_o, crc_bit21_o, crc_bit23_o;
  logic [31:0] crc_value_o;
  logic        crc_valid_i, crc_ready_o;
  logic [31:0] crc_result_i;
  logic        sonuc_valid_o, sonuc_ready_i;
  logic [31:0] sonuc_crc_o;
  logic [1:0]  durum_o;

  int total, bad;

  // environment controls
  logic rastgele, bayat;
  int   sabit_gecikme;

  // frame under test and observed request bits
  logic [31:0] f_data[$];
  logic [1:0]  f_size[$];
  logic        f_cast;
  logic [1:0]  gz_boyut[$];
  logic        gz_c[$];

  // CRC unit model state
  logic        req_hs, res_hs, bekleyen, sunulan, ist_tut;
  int          gecikme;
  logic [31:0] bek_sonuc;
  logic [34:0] tut_req;

  crc_akis_denetleyici dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_size_i(s_size_i), .s_last_i(s_last_i), .s_castagnoli_i(s_castagnoli_i),
    .crc_valid_o(crc_valid_o), .crc_ready_i(crc_ready_i), .crc_value_o(crc_value_o),
    .crc_bit20_o(crc_bit20_o), .crc_bit21_o(crc_bit21_o), .crc_bit23_o(crc_bit23_o),
    .crc_valid_i(crc_valid_i), .crc_ready_o(crc_ready_o), .crc_result_i(crc_result_i),
    .sonuc_valid_o(sonuc_valid_o), .sonuc_ready_i(sonuc_ready_i), .sonuc_crc_o(sonuc_crc_o),
    .durum_o(durum_o)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behaviour of the CRC unit: shift (value) through the reflected polynomial bit by bit.
  function automatic logic [31:0] birim_crc(input logic [31:0] v, input logic [1:0] b, input logic c);
    logic [31:0] x, p;
    int n;
    x = v;
    p = c ? 32'h82F6_3B78 : 32'hEDB8_8320;
    n = (b == 2'b00) ? 8 : (b == 2'b01) ? 16 : 32;
    for (int i = 0; i < n; i++) x = x[0] ? ((x >> 1) ^ p) : (x >> 1);
    return x;
  endfunction

  // Reference: standard CRC-32/CRC-32C over the frame's byte stream, LSB byte first.
  function automatic logic [31:0] ref_crc(input logic c);
    logic [7:0]  bytes[$];
    logic [31:0] crc, d, p;
    int nb;
    p = c ? 32'h82F6_3B78 : 32'hEDB8_8320;
    for (int i = 0; i < f_data.size(); i++) begin
      d  = f_data[i];
      nb = (f_size[i] == 2'b00) ? 1 : (f_size[i] == 2'b01) ? 2 : 4;
      for (int k = 0; k < nb; k++) bytes.push_back(d[8*k +: 8]);
    end
    crc = 32'hFFFF_FFFF;
    foreach (bytes[j]) begin
      crc = crc ^ {24'h0, bytes[j]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ p) : (crc >> 1);
    end
    return ~crc;
  endfunction

  // CRC unit model: accepts one request, answers after a latency, checks request stability.
  initial begin
    crc_ready_i = 1'b0; crc_valid_i = 1'b0; crc_result_i = '0;
    req_hs = 1'b0; res_hs = 1'b0; bekleyen = 1'b0; sunulan = 1'b0; ist_tut = 1'b0;
    gecikme = 0; bek_sonuc = '0; tut_req = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || bayat) begin
        bekleyen = 1'b0; sunulan = 1'b0; req_hs = 1'b0; res_hs = 1'b0; ist_tut = 1'b0;
        crc_ready_i  = 1'b0;
        crc_valid_i  = bayat;
        crc_result_i = bayat ? 32'hDEAD_BEEF : 32'h0;
      end else begin
        if (ist_tut) begin
          total++;
          if (crc_valid_o !== 1'b1 || {crc_bit23_o, crc_bit21_o, crc_bit20_o, crc_value_o} !== tut_req) begin
            bad++;
            $display("FAIL req_stable: got v=%b %h, need v=1 %h", crc_valid_o,
                     {crc_bit23_o, crc_bit21_o, crc_bit20_o, crc_value_o}, tut_req);
          end
        end
        if (res_hs) sunulan = 1'b0;
        if (req_hs) begin
          bekleyen  = 1'b1;
          gecikme   = rastgele ? $urandom_range(0, 4) : sabit_gecikme;
          bek_sonuc = birim_crc(tut_req[31:0], tut_req[33:32], tut_req[34]);
        end
        if (bekleyen && !sunulan) begin
          if (gecikme == 0) begin
            sunulan  = 1'b1;
            bekleyen = 1'b0;
          end else begin
            gecikme--;
          end
        end
        crc_valid_i  = sunulan;
        crc_result_i = sunulan ? bek_sonuc : $urandom;
        crc_ready_i  = rastgele ? ($urandom_range(0, 2) != 0) : 1'b1;
        req_hs  = crc_valid_o && crc_ready_i;
        res_hs  = crc_valid_i && crc_ready_o;
        ist_tut = crc_valid_o && !crc_ready_i;
        if (crc_valid_o) tut_req = {crc_bit23_o, crc_bit21_o, crc_bit20_o, crc_value_o};
        if (req_hs) begin
          gz_boyut.push_back({crc_bit21_o, crc_bit20_o});
          gz_c.push_back(crc_bit23_o);
        end
      end
    end
  end

  // Drive one beat (called at a negedge) and wait for its handshake.
  task automatic beat_gonder(input logic [31:0] d, input logic [1:0] sz, input logic last, input logic c);
    int n;
    n = 0;
    s_valid_i = 1'b1; s_data_i = d; s_size_i = sz; s_last_i = last; s_castagnoli_i = c;
    while (s_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (s_ready_o !== 1'b1) begin
      total++; bad++;
      $display("FAIL beat_timeout: s_ready_o=%b after %0d cycles, need 1", s_ready_o, n);
      s_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid_i = 1'b0; s_data_i = $urandom; s_last_i = 1'b0; s_castagnoli_i = $urandom_range(0, 1);
    total++;
    if (crc_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL req_latency: crc_valid_o=%b one cycle after beat, need 1", crc_valid_o);
    end
  endtask

  // Collect the final CRC, optionally stalling, and check it is held while stalled.
  task automatic sonuc_al(input logic stall, output logic [31:0] v, output logic ok);
    int n;
    logic [31:0] tut;
    ok = 1'b0; v = '0; n = 0;
    while (sonuc_valid_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sonuc_valid_o !== 1'b1) begin
      total++; bad++;
      $display("FAIL sonuc_timeout: sonuc_valid_o=%b after %0d cycles, need 1", sonuc_valid_o, n);
      return;
    end
    tut = sonuc_crc_o;
    n = 0;
    sonuc_ready_i = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    while (!sonuc_ready_i) begin
      @(negedge clk);
      n++;
      total++;
      if (sonuc_valid_o !== 1'b1 || sonuc_crc_o !== tut) begin
        bad++;
        $display("FAIL sonuc_stable: got v=%b crc=%h, need v=1 crc=%h", sonuc_valid_o, sonuc_crc_o, tut);
      end
      sonuc_ready_i = ($urandom_range(0, 1) == 1) || (n > 20);
    end
    v  = sonuc_crc_o;
    ok = 1'b1;
    @(negedge clk);
    sonuc_ready_i = 1'b0;
    total++;
    if (sonuc_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL after_sonuc: sonuc_valid_o=%b s_ready_o=%b, need 0 and 1", sonuc_valid_o, s_ready_o);
    end
  endtask

  // Run the frame held in f_data/f_size/f_cast and check result and request bits.
  task automatic cerceve(input string ad, input logic stall, input logic [31:0] sabit, input logic sabit_var);
    logic [31:0] beklenen, v;
    logic [1:0]  bk;
    logic        ok, c;
    beklenen = ref_crc(f_cast);
    gz_boyut.delete();
    gz_c.delete();
    rastgele = stall;
    for (int i = 0; i < f_data.size(); i++) begin
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      c = (i == 0 || !stall) ? f_cast : 1'($urandom_range(0, 1));
      beat_gonder(f_data[i], f_size[i], (i == f_data.size() - 1), c);
    end
    sonuc_al(stall, v, ok);
    if (ok) begin
      total++;
      if (v !== beklenen) begin
        bad++;
        $display("FAIL %s_model: got %h, need %h", ad, v, beklenen);
      end
      if (sabit_var) begin
        total++;
        if (v !== sabit) begin
          bad++;
          $display("FAIL %s_const: got %h, need %h", ad, v, sabit);
        end
      end
    end
    total++;
    if (gz_boyut.size() != f_data.size()) begin
      bad++;
      $display("FAIL %s_req_count: got %0d, need %0d", ad, gz_boyut.size(), f_data.size());
    end else begin
      for (int i = 0; i < f_data.size(); i++) begin
        bk = (f_size[i] == 2'b11) ? 2'b10 : f_size[i];
        total++;
        if (gz_boyut[i] !== bk || gz_c[i] !== f_cast) begin
          bad++;
          $display("FAIL %s_req_bits[%0d]: got size=%b c=%b, need size=%b c=%b",
                   ad, i, gz_boyut[i], gz_c[i], bk, f_cast);
        end
      end
    end
    rastgele = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready_o, crc_valid_o, crc_ready_o, sonuc_valid_o, crc_bit20_o, crc_bit21_o, crc_bit23_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b, need 0", {s_ready_o, crc_valid_o, crc_ready_o, sonuc_valid_o,
               crc_bit20_o, crc_bit21_o, crc_bit23_o});
    end
    total++;
    if (crc_value_o !== 32'h0 || sonuc_crc_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got value=%h sonuc=%h, need 0 0", crc_value_o, sonuc_crc_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (s_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b, need 0", s_ready_o);
    end
    @(negedge clk);
    total++;
    if (s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge: got %b, need 1", s_ready_o);
    end
  endtask

  task automatic test_tek_bayt();
    f_data = '{32'h0000_0061}; f_size = '{2'b00};
    f_cast = 1'b0; cerceve("a_crc32", 1'b0, 32'hE8B7_BE43, 1'b1);
    f_cast = 1'b1; cerceve("a_crc32c", 1'b0, 32'hC1D0_4330, 1'b1);
  endtask

  task automatic test_cok_vurus();
    f_data = '{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}; f_size = '{2'b10, 2'b10, 2'b00};
    f_cast = 1'b0; cerceve("n9_crc32", 1'b0, 32'hCBF4_3926, 1'b1);
    f_cast = 1'b1; cerceve("n9_crc32c", 1'b0, 32'hE306_9283, 1'b1);
  endtask

  task automatic test_duraklama();
    f_data = '{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}; f_size = '{2'b10, 2'b10, 2'b00};
    for (int k = 0; k < 3; k++) begin
      f_cast = 1'b0; cerceve("stall_crc32", 1'b1, 32'hCBF4_3926, 1'b1);
      f_cast = 1'b1; cerceve("stall_crc32c", 1'b1, 32'hE306_9283, 1'b1);
    end
  endtask

  task automatic test_boyut_11();
    f_data = '{32'h3433_3231, 32'h3837_3635, 32'hFFFF_FF39}; f_size = '{2'b11, 2'b10, 2'b00};
    f_cast = 1'b0; cerceve("size11", 1'b0, 32'hCBF4_3926, 1'b1);
  endtask

  task automatic test_rastgele();
    int n;
    for (int k = 0; k < 8; k++) begin
      f_data.delete(); f_size.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        f_data.push_back($urandom);
        f_size.push_back(2'($urandom_range(0, 3)));
      end
      f_cast = 1'($urandom_range(0, 1));
      cerceve("random", 1'($urandom_range(0, 1)), 32'h0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    f_data = '{32'h0000_0061}; f_size = '{2'b00}; f_cast = 1'b0;
    cerceve("b2b_first", 1'b0, 32'hE8B7_BE43, 1'b1);
    cerceve("b2b_second", 1'b0, 32'hE8B7_BE43, 1'b1);
  endtask

  task automatic test_reset_ortada();
    int n;
    n = 0;
    sabit_gecikme = 20;
    beat_gonder(32'h0000_0061, 2'b00, 1'b1, 1'b0);
    while (durum_o !== 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (durum_o !== 2'd2) begin
      bad++;
      $display("FAIL reach_wait: durum_o=%0d, need 2", durum_o);
    end
    #2 rst_n = 1'b0;
    bayat = 1'b1;
    #1;
    total++;
    if ({s_ready_o, crc_valid_o, crc_ready_o, sonuc_valid_o, crc_bit20_o, crc_bit21_o, crc_bit23_o} !== 7'b0
        || crc_value_o !== 32'h0 || sonuc_crc_o !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: flags=%b value=%h sonuc=%h, need all 0",
               {s_ready_o, crc_valid_o, crc_ready_o, sonuc_valid_o, crc_bit20_o, crc_bit21_o, crc_bit23_o},
               crc_value_o, sonuc_crc_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (durum_o !== 2'd0 || crc_ready_o !== 1'b0 || sonuc_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stale_result: durum=%0d crc_ready_o=%b sonuc_valid_o=%b, need 0 0 0",
               durum_o, crc_ready_o, sonuc_valid_o);
    end
    bayat = 1'b0;
    sabit_gecikme = 0;
    @(negedge clk);
    f_data = '{32'h0000_0061}; f_size = '{2'b00}; f_cast = 1'b0;
    cerceve("after_reset_a", 1'b0, 32'hE8B7_BE43, 1'b1);
  endtask

  // Test sequence.
  initial begin
    total = 0; bad = 0;
    rastgele = 1'b0; bayat = 1'b0; sabit_gecikme = 0;
    s_valid_i = 1'b0; s_data_i = '0; s_size_i = 2'b00; s_last_i = 1'b0; s_castagnoli_i = 1'b0;
    sonuc_ready_i = 1'b0;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_tek_bayt();
    test_cok_vurus();
    test_duraklama();
    test_boyut_11();
    test_rastgele();
    test_back_to_back();
    test_reset_ortada();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
